// File: rtl/fwd_kinematics_engine.sv
// Forward kinematics for a 3-joint arm (base yaw, shoulder pitch, elbow pitch).
// One shared two-stage piecewise-linear cosine unit evaluates all six trig terms.

module fkin_cos_lut (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        angle,
    output logic signed [31:0] cos_val
);
    // round(2^30 * cos(2*pi*i/4096)), ties away from zero; index wraps mod 4096
    function automatic logic signed [31:0] cos_code(input int i);
        real v;
        v = 1073741824.0 * $cos(6.283185307179586 * real'(i % 4096) / 4096.0);
        if (v >= 0.0)
            cos_code = $rtoi(v + 0.5);
        else
            cos_code = -$rtoi(0.5 - v);
    endfunction

    logic signed [31:0] b_rom [4096];
    logic signed [31:0] m_rom [4096];

    generate
        for (genvar gi = 0; gi < 4096; gi++) begin : g_rom
            localparam logic signed [31:0] B_I = cos_code(gi);
            localparam logic signed [31:0] M_I = cos_code(gi + 1) - cos_code(gi);
            assign b_rom[gi] = B_I;
            assign m_rom[gi] = M_I;
        end
    endgenerate

    logic signed [31:0] b_reg;
    logic signed [31:0] m_reg;
    logic [19:0]        frac_reg;
    logic signed [31:0] cos_reg;

    logic signed [63:0] m_ext;
    logic signed [63:0] frac_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] interp;

    assign m_ext    = {{32{m_reg[31]}}, m_reg};
    assign frac_ext = {44'd0, frac_reg};
    assign b_ext    = {{32{b_reg[31]}}, b_reg};
    // arithmetic shift floors the slope correction, including negative gradients
    assign interp   = b_ext + ((m_ext * frac_ext) >>> 20);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg    <= '0;
            m_reg    <= '0;
            frac_reg <= '0;
            cos_reg  <= '0;
        end else begin
            b_reg    <= b_rom[angle[31:20]];
            m_reg    <= m_rom[angle[31:20]];
            frac_reg <= angle[19:0];
            cos_reg  <= interp[31:0];
        end
    end

    assign cos_val = cos_reg;
endmodule

module fwd_kinematics_engine #(
    parameter logic [15:0] L0 = 16'd100,
    parameter logic [15:0] L1 = 16'd120,
    parameter logic [15:0] L2 = 16'd100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        theta0,
    input  logic [31:0]        theta1,
    input  logic [31:0]        theta2,
    output logic               busy,
    output logic               done,
    output logic signed [63:0] x,
    output logic signed [63:0] y,
    output logic signed [63:0] z
);
    typedef enum logic [1:0] {IDLE, TRIG, RADIAL, OUTPUT} state_t;

    localparam logic [31:0] QUARTER = 32'h4000_0000;

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg;
    logic [31:0]        theta0_reg, theta1_reg, theta12_reg;
    logic [31:0]        issue_angle;
    logic signed [31:0] cos_val;
    // capture order: c0, s0, c1, s1, c12, s12
    logic signed [31:0] res_reg [6];
    logic signed [63:0] x_reg, y_reg, z_reg;

    fkin_cos_lut u_cos (
        .clk     (clk),
        .rst_n   (rst_n),
        .angle   (issue_angle),
        .cos_val (cos_val)
    );

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b0;
        done        = 1'b0;
        issue_angle = '0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = TRIG;
            end
            TRIG: begin
                busy = 1'b1;
                case (cnt_reg)
                    3'd0:    issue_angle = theta0_reg;
                    3'd1:    issue_angle = theta0_reg - QUARTER;
                    3'd2:    issue_angle = theta1_reg;
                    3'd3:    issue_angle = theta1_reg - QUARTER;
                    3'd4:    issue_angle = theta12_reg;
                    3'd5:    issue_angle = theta12_reg - QUARTER;
                    default: issue_angle = '0;
                endcase
                if (cnt_reg == 3'd7) state_next = RADIAL;
            end
            RADIAL: begin
                busy       = 1'b1;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic signed [63:0] c0_e, s0_e, c1_e, s1_e, c12_e, s12_e;
    logic signed [63:0] l0_e, l1_e, l2_e;
    logic signed [63:0] r_next, x_next, y_next, z_next;

    assign c0_e  = {{32{res_reg[0][31]}}, res_reg[0]};
    assign s0_e  = {{32{res_reg[1][31]}}, res_reg[1]};
    assign c1_e  = {{32{res_reg[2][31]}}, res_reg[2]};
    assign s1_e  = {{32{res_reg[3][31]}}, res_reg[3]};
    assign c12_e = {{32{res_reg[4][31]}}, res_reg[4]};
    assign s12_e = {{32{res_reg[5][31]}}, res_reg[5]};
    assign l0_e  = {48'd0, L0};
    assign l1_e  = {48'd0, L1};
    assign l2_e  = {48'd0, L2};

    // Q2.30 trig times integer lengths, shifted down to Q16
    assign r_next = (l1_e * c1_e + l2_e * c12_e) >>> 14;
    assign x_next = (c0_e * r_next) >>> 30;
    assign y_next = (s0_e * r_next) >>> 30;
    assign z_next = (l0_e <<< 16) + ((l1_e * s1_e + l2_e * s12_e) >>> 14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            theta0_reg  <= '0;
            theta1_reg  <= '0;
            theta12_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            for (int i = 0; i < 6; i++) res_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                theta0_reg  <= theta0;
                theta1_reg  <= theta1;
                theta12_reg <= theta1 + theta2;
            end
            cnt_reg <= (state_reg == TRIG) ? cnt_reg + 3'd1 : 3'd0;
            // result of issue i leaves the cosine pipe two cycles after it was presented
            for (int i = 0; i < 6; i++) begin
                if (state_reg == TRIG && cnt_reg == 3'(i + 2)) res_reg[i] <= cos_val;
            end
            if (state_reg == RADIAL) begin
                x_reg <= x_next;
                y_reg <= y_next;
                z_reg <= z_next;
            end
        end
    end

    assign x = x_reg;
    assign y = y_reg;
    assign z = z_reg;
endmodule

// File: tb/tb_fwd_kinematics_engine.sv
// Scoreboard bench for fwd_kinematics_engine plus direct probing of its cosine unit.

module tb_fwd_kinematics_engine;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        theta0 = '0, theta1 = '0, theta2 = '0;
    logic               busy, done;
    logic signed [63:0] x, y, z;

    logic [31:0]        probe_angle = '0;
    logic signed [31:0] probe_cos;
    logic               probe_vld = 1'b0, vld1 = 1'b0, vld2 = 1'b0;

    int     n_vec = 0;
    int     n_err = 0;
    int     done_cnt = 0;
    longint cyc = 0, start_cyc = 0, done_cyc = 0, prev_done_cyc = 0;
    longint last_x = 0, last_z = 0;
    longint b_tab [4096];

    typedef struct {
        longint ex;
        longint ey;
        longint ez;
        bit     chk_lat;
    } fk_exp_t;

    typedef struct {
        string  tag;
        longint ev;
        bit     tol;
        real    truth;
    } cos_exp_t;

    fk_exp_t  fk_q [$];
    cos_exp_t cos_q [$];

    fwd_kinematics_engine dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .theta0 (theta0),
        .theta1 (theta1),
        .theta2 (theta2),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .y      (y),
        .z      (z)
    );

    fkin_cos_lut u_probe (
        .clk     (clk),
        .rst_n   (rst_n),
        .angle   (probe_angle),
        .cos_val (probe_cos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        vld1 <= probe_vld;
        vld2 <= vld1;
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_cos(input logic [31:0] a);
        int     idx;
        longint frac, bb, mm;
        idx  = int'(a[31:20]);
        frac = longint'(a[19:0]);
        bb   = b_tab[idx];
        mm   = b_tab[(idx + 1) % 4096] - bb;
        return bb + ((mm * frac) >>> 20);
    endfunction

    task automatic model_fk(input logic [31:0] a0, a1, a2,
                            output longint ex, output longint ey, output longint ez);
        longint c0, s0, c1, s1, c12, s12, r;
        logic [31:0] a12;
        a12 = a1 + a2;
        c0  = model_cos(a0);
        s0  = model_cos(a0 - 32'h4000_0000);
        c1  = model_cos(a1);
        s1  = model_cos(a1 - 32'h4000_0000);
        c12 = model_cos(a12);
        s12 = model_cos(a12 - 32'h4000_0000);
        r   = (120 * c1 + 100 * c12) >>> 14;
        ex  = (c0 * r) >>> 30;
        ey  = (s0 * r) >>> 30;
        ez  = (longint'(100) <<< 16) + ((120 * s1 + 100 * s12) >>> 14);
    endtask

    // cosine-unit scoreboard
    always @(negedge clk) begin
        if (rst_n && vld2) begin
            cos_exp_t e;
            real d;
            e = cos_q.pop_front();
            check_val(e.tag, longint'(probe_cos), e.ev);
            if (e.tol) begin
                d = real'(probe_cos) - e.truth;
                check_val({e.tag, "_accuracy"}, longint'((d <= 320.0 && d >= -320.0) ? 1 : 0), 1);
            end
        end
    end

    // engine scoreboard
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            if (fk_q.size() == 0) begin
                check_val("done_without_request", longint'(done), 0);
            end else begin
                fk_exp_t e;
                e = fk_q.pop_front();
                check_val("x", x, e.ex);
                check_val("y", y, e.ey);
                check_val("z", z, e.ez);
                check_val("busy_at_done", longint'(busy), 0);
                if (e.chk_lat) check_val("latency", cyc - start_cyc, 10);
                $display("fk #%0d x=%0d y=%0d z=%0d (expected %0d %0d %0d)",
                         done_cnt, x, y, z, e.ex, e.ey, e.ez);
            end
            last_x = x;
            last_z = z;
        end
    end

    task automatic probe(input logic [31:0] a, input string tag, input bit use_const,
                         input longint cv, input bit tol);
        cos_exp_t e;
        @(negedge clk);
        probe_angle = a;
        probe_vld   = 1'b1;
        e.tag   = tag;
        e.ev    = use_const ? cv : model_cos(a);
        e.tol   = tol;
        e.truth = 1073741824.0 * $cos(6.283185307179586 * real'(a) / 4294967296.0);
        cos_q.push_back(e);
    endtask

    task automatic wait_dones(input int base, input int want, input int budget);
        for (int i = 0; i < budget && done_cnt < base + want; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_fk(input logic [31:0] a0, a1, a2, input bit use_const,
                          input longint cx, cy, cz);
        fk_exp_t e;
        int      n0;
        @(negedge clk);
        theta0 = a0;
        theta1 = a1;
        theta2 = a2;
        start  = 1'b1;
        start_cyc = cyc;
        if (use_const) begin
            e.ex = cx; e.ey = cy; e.ez = cz;
        end else begin
            model_fk(a0, a1, a2, e.ex, e.ey, e.ez);
        end
        e.chk_lat = 1'b1;
        fk_q.push_back(e);
        n0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_accept", longint'(busy), 1);
        wait_dones(n0, 1, 20);
        check_val("done_count", longint'(done_cnt - n0), 1);
    endtask

    initial begin
        longint rc;
        int     n0;
        fk_exp_t e;
        logic [31:0] ra, rb, rcode;

        for (int i = 0; i < 4096; i++)
            b_tab[i] = longint'(1073741824.0 * $cos(6.283185307179586 * real'(i) / 4096.0));

        repeat (3) @(negedge clk);
        check_val("reset_busy", longint'(busy), 0);
        check_val("reset_done", longint'(done), 0);
        check_val("reset_x", x, 0);
        check_val("reset_y", y, 0);
        check_val("reset_z", z, 0);
        check_val("reset_cos", longint'(probe_cos), 0);
        rst_n = 1'b1;

        probe(32'h0000_0000, "cos_0",        1'b1, 1073741824,  1'b0);
        probe(32'h4000_0000, "cos_quarter",  1'b1, 0,           1'b0);
        probe(32'h8000_0000, "cos_half",     1'b1, -1073741824, 1'b0);
        probe(32'hFFFF_FFFC, "cos_wrap4095", 1'b1, 1073741823,  1'b0);
        probe(32'hC000_0000, "cos_b3072",    1'b1, 0,           1'b0);
        probe(32'hFFF0_0000, "cos_b4095",    1'b1, 1073740561,  1'b0);
        probe(32'hFFFF_FFFF, "cos_max",      1'b0, 0,           1'b1);
        for (int i = 0; i < 4096; i++) probe(32'(i) << 20, "cos_sweep", 1'b0, 0, 1'b1);
        for (int i = 0; i < 200; i++)  probe($urandom, "cos_rand", 1'b0, 0, 1'b1);
        @(negedge clk);
        probe_vld = 1'b0;
        repeat (4) @(negedge clk);

        run_fk(32'h0, 32'h0, 32'h0, 1'b1, 14417920, 0, 6553600);
        run_fk(32'h0, 32'h4000_0000, 32'h0, 1'b1, 0, 0, 20971520);
        run_fk(32'h4000_0000, 32'h0, 32'h0, 1'b1, 0, 14417920, 6553600);
        run_fk(32'h8000_0000, 32'h0, 32'h0, 1'b1, -14417920, 0, 6553600);
        run_fk(32'h1, 32'h1, 32'h1, 1'b0, 0, 0, 0);
        check_val("x_near_reach", longint'((last_x >= 14417918 && last_x <= 14417922) ? 1 : 0), 1);
        check_val("z_near_base",  longint'((last_z >= 6553598 && last_z <= 6553602) ? 1 : 0), 1);
        run_fk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0, 0);

        rc    = longint'(-3.665191429 / 6.283185307179586 * 4294967296.0);
        rcode = rc[31:0];
        run_fk(rcode, 32'h2000_0000, rcode, 1'b0, 0, 0, 0);
        for (int i = 0; i < 6; i++) run_fk($urandom, $urandom, $urandom, 1'b0, 0, 0, 0);

        // second start while busy must be dropped
        n0 = done_cnt;
        @(negedge clk);
        theta0 = 32'h1234_5678; theta1 = 32'h0800_0000; theta2 = 32'hF000_0000;
        start = 1'b1;
        start_cyc = cyc;
        model_fk(theta0, theta1, theta2, e.ex, e.ey, e.ez);
        e.chk_lat = 1'b1;
        fk_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        theta0 = 32'h0; theta1 = 32'h0; theta2 = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check_val("start_while_busy_dones", longint'(done_cnt - n0), 1);

        // start held high: accepts again in the cycle after done
        n0 = done_cnt;
        @(negedge clk);
        theta0 = 32'h0; theta1 = 32'h0; theta2 = 32'h0;
        start = 1'b1;
        e.ex = 14417920; e.ey = 0; e.ez = 6553600; e.chk_lat = 1'b0;
        fk_q.push_back(e);
        fk_q.push_back(e);
        for (int i = 0; i < 40 && done_cnt < n0 + 2; i++) @(negedge clk);
        start = 1'b0;
        check_val("b2b_dones", longint'(done_cnt - n0), 2);
        check_val("b2b_gap", done_cyc - prev_done_cyc, 11);
        repeat (15) @(negedge clk);
        check_val("b2b_no_third", longint'(done_cnt - n0), 2);

        // reset in cycle 5 of an operation
        n0 = done_cnt;
        @(negedge clk);
        theta0 = 32'h1000_0000; theta1 = 32'h0; theta2 = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", longint'(busy), 0);
        check_val("abort_done", longint'(done), 0);
        check_val("abort_x", x, 0);
        check_val("abort_y", y, 0);
        check_val("abort_z", z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_val("abort_no_done", longint'(done_cnt - n0), 0);
        check_val("abort_x_held", x, 0);
        check_val("scoreboard_empty", longint'(fk_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
